// File: rtl/tpose_pkg.sv
// tpose_pkg: shared types for the streaming ping-pong transposer.
// Bank lifecycle, output flag layout and row-index sizing.
package tpose_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  localparam int SF_V = 0;
  localparam int SF_E = 1;
  localparam int SF_W = 2;

  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/tpose_bank.sv
// tpose_bank: one N x N transpose buffer with row write, column read.
// Rows beyond the written count read as zero via the rows mask.
module tpose_bank
  import tpose_pkg::*;
#(
  parameter  int W  = 16,
  parameter  int N  = 8,
  localparam int CW = $clog2(N),
  localparam int IW = idx_w(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic           wr_last,
  input  logic [CW-1:0]  wr_row,
  input  logic [N*W-1:0] wr_data,
  input  logic           seal,
  input  logic           rd_go,
  input  logic           rd_done,
  input  logic [CW-1:0]  rd_col,
  output bank_state_e    state,
  output logic [IW-1:0]  rows,
  output logic           eos,
  output logic [N*W-1:0] rd_data
);

  logic [W-1:0] mem [N][N];

  // Storage is never cleared; stale rows are hidden by rows.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < N; i++)
        mem[wr_row][i] <= wr_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BANK_EMPTY;
      rows  <= '0;
      eos   <= 1'b0;
    end else if (rd_done) begin
      state <= BANK_EMPTY;
      rows  <= '0;
      eos   <= 1'b0;
    end else if (rd_go) begin
      state <= BANK_DRAINING;
    end else if (seal) begin
      state <= BANK_FULL;
      eos   <= 1'b1;
    end else if (wr_en) begin
      rows  <= {1'b0, wr_row} + IW'(1);
      state <= wr_last ? BANK_FULL : BANK_FILLING;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) < rows)
        rd_data[i*W +: W] = mem[i][rd_col];
    end
  end

endmodule

// File: rtl/tpose_stream_pp.sv
// tpose_stream_pp: streaming N x N transposer, rows in, columns out.
// TPOSE_PINGPONG_EN selects two banks; otherwise a single bank.
module tpose_stream_pp
  import tpose_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N*W-1:0] a_d,
  input  logic [N-1:0]   a_e,
  input  logic [N-1:0]   a_v,
  output logic [N-1:0]   a_b,
  output logic [N*W-1:0] b_d,
  output logic [N-1:0]   b_e,
  output logic [N-1:0]   b_v,
  input  logic [N-1:0]   b_b
);

  localparam int CW = $clog2(N);
  localparam int IW = idx_w(N);
`ifdef TPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic PP = (NB == 2);

  logic            fill_sel;
  logic            drain_sel;
  logic [CW-1:0]   wr_row;
  logic [IW-1:0]   rd_col;
  logic [SF_W-1:0] flags;
  logic [N*W-1:0]  out_d;

  bank_state_e     bst   [NB];
  logic [IW-1:0]   brows [NB];
  logic            beos  [NB];
  logic [N*W-1:0]  bcol  [NB];

  bank_state_e     f_st;
  bank_state_e     d_st;
  logic [IW-1:0]   d_rows;
  logic            d_eos;
  logic [N*W-1:0]  d_col;

  logic stall;
  logic acc;
  logic eos_row;
  logic row_go;
  logic row_last;
  logic load;
  logic have;
  logic emit;
  logic eos_col;
  logic last;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic mine_f;
    logic mine_d;
    assign mine_f = (fill_sel == 1'(b));
    assign mine_d = (drain_sel == 1'(b));
    tpose_bank #(.W(W), .N(N)) u_bank (
      .clk     (clock),
      .rst_n   (reset),
      .wr_en   (row_go && mine_f),
      .wr_last (row_last),
      .wr_row  (wr_row),
      .wr_data (a_d),
      .seal    (eos_row && mine_f),
      .rd_go   (emit && mine_d),
      .rd_done (emit && last && mine_d),
      .rd_col  (rd_col[CW-1:0]),
      .state   (bst[b]),
      .rows    (brows[b]),
      .eos     (beos[b]),
      .rd_data (bcol[b])
    );
  end

  if (NB == 2) begin : g_pp
    assign f_st   = fill_sel  ? bst[1]   : bst[0];
    assign d_st   = drain_sel ? bst[1]   : bst[0];
    assign d_rows = drain_sel ? brows[1] : brows[0];
    assign d_eos  = drain_sel ? beos[1]  : beos[0];
    assign d_col  = drain_sel ? bcol[1]  : bcol[0];
  end else begin : g_sp
    assign f_st   = bst[0];
    assign d_st   = bst[0];
    assign d_rows = brows[0];
    assign d_eos  = beos[0];
    assign d_col  = bcol[0];
  end

  always_comb begin
    stall    = !(f_st inside {BANK_EMPTY, BANK_FILLING});
    acc      = (&a_v) && !stall;
    eos_row  = acc && (|a_e);
    row_go   = acc && !eos_row;
    row_last = &wr_row;
    load     = !flags[SF_V] || !(|b_b);
    have     = d_st inside {BANK_FULL, BANK_DRAINING};
    emit     = load && have;
    // Column index N is the trailing EOS column.
    eos_col  = (d_rows == '0) || (rd_col == IW'(N));
    last     = eos_col || ((rd_col == IW'(N-1)) && !d_eos);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_sel  <= 1'b0;
      drain_sel <= 1'b0;
      wr_row    <= '0;
      rd_col    <= '0;
      flags     <= '0;
      out_d     <= '0;
    end else begin
      if (eos_row || (row_go && row_last)) begin
        wr_row   <= '0;
        fill_sel <= fill_sel ^ PP;
      end else if (row_go) begin
        wr_row <= wr_row + CW'(1);
      end
      if (emit) begin
        rd_col <= last ? '0 : rd_col + IW'(1);
        if (last)
          drain_sel <= drain_sel ^ PP;
      end
      if (load) begin
        flags[SF_V] <= have;
        flags[SF_E] <= have && eos_col;
        out_d       <= (have && !eos_col) ? d_col : '0;
      end
    end
  end

  assign a_b = {N{stall}};
  assign b_v = {N{flags[SF_V]}};
  assign b_e = {N{flags[SF_E]}};
  assign b_d = out_d;

endmodule

// File: tb/tb_tpose_stream_pp.sv
// tb_tpose_stream_pp: directed checks for the streaming transposer.
// Block table plus hand-written stall, partial-valid and reset sequences.
module tb_tpose_stream_pp;

  localparam int W = 16;
  localparam int N = 8;
  localparam logic [N-1:0] ONES = '1;
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N*W-1:0] DZERO = '0;
`ifdef TPOSE_PINGPONG_EN
  localparam logic [N-1:0] AB_FULL = '0;
  localparam int GAP = 1;
`else
  localparam logic [N-1:0] AB_FULL = '1;
  localparam int GAP = N + 1;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic [N*W-1:0] a_d;
  logic [N-1:0]   a_e;
  logic [N-1:0]   a_v;
  logic [N-1:0]   a_b;
  logic [N*W-1:0] b_d;
  logic [N-1:0]   b_e;
  logic [N-1:0]   b_v;
  logic [N-1:0]   b_b;

  typedef struct {
    int base;
    int nrows;
    bit eos;
    int exp_cols;
    bit exp_eos;
  } blk_t;

  typedef struct {
    logic [N-1:0]   v;
    logic [N-1:0]   e;
    logic [N*W-1:0] d;
    int             cyc;
  } cap_t;

  cap_t cap[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  tpose_stream_pp #(.W(W), .N(N)) dut (
    .clock (clock),
    .reset (reset),
    .a_d   (a_d),
    .a_e   (a_e),
    .a_v   (a_v),
    .a_b   (a_b),
    .b_d   (b_d),
    .b_e   (b_e),
    .b_v   (b_v),
    .b_b   (b_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // A column transfers at the next rising edge when valid and not stalled.
  always @(negedge clock)
    if (reset && b_v[0] && b_b == '0)
      cap.push_back('{b_v, b_e, b_d, cyc});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*W-1:0] mk_row(input int base, input int k);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(base + N*k + i);
    return r;
  endfunction

  function automatic logic [N*W-1:0] mk_col(input int base, input int nrows,
                                            input int j);
    logic [N*W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      if (i < nrows) c[i*W +: W] = W'(base + N*i + j);
    return c;
  endfunction

  function automatic int get_cyc(input int i);
    if (i < cap.size()) return cap[i].cyc;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [N-1:0] act,
                      input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cmp_cap(input int i, input logic [N*W-1:0] d,
                         input logic [N-1:0] e, input string name);
    if (i < cap.size()) begin
      chk($sformatf("%s[%0d]_d", name, i), cap[i].d, d);
      chk8($sformatf("%s[%0d]_e", name, i), cap[i].e, e);
      chk8($sformatf("%s[%0d]_v", name, i), cap[i].v, ONES);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s[%0d]: got no column want one", name, i);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_row(input logic [N*W-1:0] d, input logic eos,
                          output int acc);
    int t;
    t = 0;
    a_d = d;
    a_e = eos ? ONES : ZERO;
    a_v = ONES;
    while (a_b != '0 && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    chki("send_stall_bound", int'(t < 300), 1);
    @(posedge clock); #1;
    acc = cyc;
    a_v = '0;
    a_e = '0;
  endtask

  task automatic wait_caps(input int n, input string name);
    int t;
    t = 0;
    while (cap.size() < n && t < 500) begin
      @(posedge clock); #1;
      t++;
    end
    repeat (12) begin
      @(posedge clock); #1;
    end
    chki(name, cap.size(), n);
  endtask

  initial begin
    blk_t tbl[5];
    int   done_acc[5];
    int   acc;
    int   acc2;
    int   idx;
    int   tot;
    int   t;
    logic [N*W-1:0] snap;

    tbl[0] = '{0,   8, 1'b0, 8, 1'b0};
    tbl[1] = '{64,  8, 1'b0, 8, 1'b0};
    tbl[2] = '{256, 3, 1'b1, 8, 1'b1};
    tbl[3] = '{0,   0, 1'b1, 0, 1'b1};
    tbl[4] = '{512, 8, 1'b1, 8, 1'b1};

    reset = 1'b0;
    a_d = '0;
    a_e = '0;
    a_v = '0;
    b_b = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    chk8("rst_bv", b_v, ZERO);
    chk8("rst_be", b_e, ZERO);
    chk("rst_bd", b_d, DZERO);
    chk8("rst_ab", a_b, ZERO);

    // Block table: full blocks, partial+EOS, EOS-only, full+EOS.
    cap.delete();
    tot = 0;
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < tbl[r].nrows; k++)
        send_row(mk_row(tbl[r].base, k), 1'b0, acc);
      if (tbl[r].eos)
        send_row(mk_row(9000, r), 1'b1, acc);
      done_acc[r] = acc;
      tot += tbl[r].exp_cols + int'(tbl[r].exp_eos);
      if (r == 0) begin
        chk8("ab_after_full", a_b, AB_FULL);
        chk8("bv_before_latency", b_v, ZERO);
      end
    end
    wait_caps(tot, "tbl_count");
    idx = 0;
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < tbl[r].exp_cols; j++) begin
        cmp_cap(idx, mk_col(tbl[r].base, tbl[r].nrows, j), ZERO, "tbl");
        idx++;
      end
      if (tbl[r].exp_eos) begin
        cmp_cap(idx, DZERO, ONES, "tbl_eos");
        idx++;
      end
    end
    chki("lat_blk0", get_cyc(0), done_acc[0] + 1);
    chki("lat_blk1", get_cyc(8), done_acc[1] + 1);
    chki("gap_blk01", get_cyc(8) - get_cyc(7), GAP);

    // Downstream stall mid-drain while three blocks stream in.
    cap.delete();
    fork
      begin
        for (int k = 0; k < 24; k++)
          send_row(mk_row(1024, k), 1'b0, acc2);
      end
      begin
        t = 0;
        while (cap.size() < 2 && t < 200) begin
          @(posedge clock); #1;
          t++;
        end
        chki("stall_start_bound", int'(t < 200), 1);
        b_b  = ONES;
        snap = b_d;
        chk8("stall_bv", b_v, ONES);
        for (int c = 0; c < 10; c++) begin
          @(posedge clock); #1;
          chk($sformatf("stall_hold%0d", c), b_d, snap);
        end
        chk8("stall_ab", a_b, ONES);
        b_b = '0;
      end
    join
    wait_caps(24, "stall_count");
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < N; j++)
        cmp_cap(b*N + j, mk_col(1024 + 64*b, 8, j), ZERO, "stall");

    // Partial valid must not accept the row.
    cap.delete();
    for (int k = 0; k < 7; k++)
      send_row(mk_row(2048, k), 1'b0, acc);
    a_d = mk_row(7777, 0);
    a_v = 8'hFE;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      chk8($sformatf("pv_no_out%0d", c), b_v, ZERO);
    end
    a_v = '0;
    send_row(mk_row(2048, 7), 1'b0, acc);
    wait_caps(8, "pv_count");
    for (int j = 0; j < N; j++)
      cmp_cap(j, mk_col(2048, 8, j), ZERO, "pv");

    // Reset with data buffered and an output column held.
    b_b = ONES;
    for (int k = 0; k < 8; k++)
      send_row(mk_row(3000, k), 1'b0, acc);
`ifdef TPOSE_PINGPONG_EN
    for (int k = 0; k < 5; k++)
      send_row(mk_row(3064, k), 1'b0, acc);
`else
    repeat (2) begin
      @(posedge clock); #1;
    end
    chk8("sp_ab_drain", a_b, ONES);
`endif
    chk8("pre_rst_bv", b_v, ONES);
    reset = 1'b0;
    #1;
    chk8("mid_rst_bv", b_v, ZERO);
    chk8("mid_rst_be", b_e, ZERO);
    chk("mid_rst_bd", b_d, DZERO);
    chk8("mid_rst_ab", a_b, ZERO);
    @(posedge clock); #1;
    reset = 1'b1;
    b_b = '0;
    cap.delete();

    // EOS-only block right after reset, then fresh blocks over stale storage.
    send_row(mk_row(5555, 0), 1'b1, acc);
    wait_caps(1, "eos_only_count");
    cmp_cap(0, DZERO, ONES, "eos_only");
    chki("eos_only_lat", get_cyc(0), acc + 1);
    for (int k = 0; k < 3; k++)
      send_row(mk_row(4000, k), 1'b0, acc);
    send_row(mk_row(6000, 0), 1'b1, acc);
    for (int k = 0; k < 8; k++)
      send_row(mk_row(4200, k), 1'b0, acc);
    wait_caps(18, "post_rst_count");
    for (int j = 0; j < N; j++)
      cmp_cap(1 + j, mk_col(4000, 3, j), ZERO, "post_part");
    cmp_cap(9, DZERO, ONES, "post_eos");
    for (int j = 0; j < N; j++)
      cmp_cap(10 + j, mk_col(4200, 8, j), ZERO, "post_full");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpose_stream_pp.md
# tpose_stream_pp

Parametrised streaming N×N matrix transposer with ping-pong banks, the next-generation successor to the fixed 8×16-bit transpose operator used between the row and column IDCT passes of the JPEG decode pipeline. It accepts one matrix row per transfer across N lockstep input streams and emits one column per transfer across N output streams. It also defines end-of-stream and partial-block behaviour. The block sits inside a page wrapper, directly behind the page's output queues, and uses the codebase's data/eos/valid/back-pressure stream protocol.

## Interface
- W, 16, data width per channel
- N, 8, channel count and matrix dimension; must be a power of two, 2..16
- clock  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- a_d  in  N*W  input row; channel i occupies bits [i*W +: W]
- a_e  in  N  per-channel end-of-stream flag
- a_v  in  N  per-channel valid
- a_b  out  N  per-channel back-pressure; 1 = stall
- b_d  out  N*W  output column; channel i occupies bits [i*W +: W]
- b_e  out  N  per-channel end-of-stream flag
- b_v  out  N  per-channel valid
- b_b  in  N  per-channel downstream back-pressure

## Operation
- Transfer rules:
  - An input row is accepted only when all a_v[i]=1 and a_b=0.
  - All a_b bits are identical. All b_v/b_e bits are identical.
  - An output column advances only when all b_b[i]=0.
- Row k written to the fill bank gives M[k][i] = a_d channel i. Drain column j drives b_d channel i = M[i][j].
- Each bank holds: state EMPTY → FILLING → FULL → DRAINING → EMPTY; row count rows (0..N); flag eos.
- Fill side:
  - wr_row counts 0..N-1.
  - At row N-1 the bank goes FULL and the fill side switches to the other bank.
- EOS row: any a_e[i]=1 while all valid. All channels are consumed and the row data is ignored.
  - The fill bank is sealed FULL with rows=wr_row and eos=1. wr_row resets to 0.
  - Unwritten rows read as zero (row-valid mask, no clearing of storage).
- Drain side:
  - If rows>0, emit N columns with b_e=0.
  - Then, if eos=1, emit one column with b_e=1 and b_d=0.
  - rows=0 with eos=1 emits only the EOS column.
  - Then the bank goes EMPTY and draining moves to the other bank. Banks drain in fill order.
- a_b=1 iff the current fill bank is not EMPTY/FILLING. a_b depends on registered state only; there is no combinational path from b_b.

## Timing
- Reset values:
  - b_v=0, b_e=0, b_d=0, a_b=0.
  - Both banks EMPTY; all counters 0.
  - Fill and drain both point to bank 0.
- Reset mid-operation discards all buffered data and pending EOS.
- Output register stage: loads when b_v=0 or all b_b=0.
- Latency: if row N-1 is accepted at cycle t, column 0 is valid at t+1.
- Throughput with the macro defined: 1 row/cycle in and 1 column/cycle out, sustained, with no bubbles between blocks.
- Simultaneous events:
  - A bank drained to EMPTY in cycle t is fillable at t+1.
  - Fill of bank X and drain of bank Y in the same cycle are always legal.
- Back-pressure held on b_b freezes b_d/b_e/b_v unchanged.

## Configuration
- TPOSE_PINGPONG_EN defined: two banks, with the full-throughput behaviour above.
- Undefined: single bank.
  - a_b=1 from the cycle after row N-1 (or an EOS row) is accepted until the final drain column transfers.
  - Peak throughput is one block per 2N cycles.
  - Ports and results are identical to the defined case.

## Structure
- Package tpose_pkg holds:
  - bank state enum (EMPTY, FILLING, FULL, DRAINING)
  - index width constant clog2(N)+1 for rows
  - the stream flag bit positions
- Sub-module tpose_bank (one per bank):
  - N×N×W register array
  - row write port; column read port
  - rows/eos bookkeeping and row-valid mask
- The top level holds the fill/drain sequencing, the handshakes and the output register.

## Test plan
- N=8, rows k with data 8k+i, no stall → b cycle j, channel i = 8i+j; first valid 1 cycle after row 7; 16 rows give 16 back-to-back columns.
- 3 rows then EOS → 8 columns where channels 0..2 carry data and 3..7 carry 0, then one column with b_e=0xFF and b_d=0.
- EOS only (immediately after reset) → exactly one output column, b_e all 1, b_v all 1; then idle.
- b_b=0xFF held 5 cycles mid-drain → b_d stable; both banks fill, then a_b=0xFF; release → no data lost, order preserved.
- a_v=0xFE for 4 cycles → no row accepted, wr_row unchanged; a_v=0xFF → row accepted.
- Assert reset with 5 rows buffered → outputs at reset values immediately; after release a fresh block transposes correctly. Repeat with TPOSE_PINGPONG_EN undefined and check a_b=1 during drain.
